// File: rtl/gshare_btb_predictor_if.sv
// Fetch-side lookup and execute-side resolution signals of the branch
// predictor. The pipeline drives through master; the predictor sits on slave.
interface gshare_btb_predictor_if #(
    parameter int HIST_W = 10
);
    // IF-stage lookup
    logic              pred_req;
    logic              stall;
    logic [31:0]       pred_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              pred_btb_hit;
    logic [HIST_W-1:0] pred_hist;

    // EX-stage resolution
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_branch;
    logic              upd_jump;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;

    modport master (
        output pred_req, stall, pred_pc,
        output upd_valid, upd_pc, upd_hist, upd_branch, upd_jump,
        output upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_target, pred_btb_hit, pred_hist
    );

    modport slave (
        input  pred_req, stall, pred_pc,
        input  upd_valid, upd_pc, upd_hist, upd_branch, upd_jump,
        input  upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_target, pred_btb_hit, pred_hist
    );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Branch predictor: PHT of saturating counters (bimodal or gshare indexed),
// tagged BTB and non-speculative global history. The arrays have no reset;
// an INIT sweep clears one entry per cycle so they can live in SRAM.
// Lookup is combinational; updates land on the clock edge with no bypass.
module gshare_btb_predictor #(
    parameter int IDX_W  = 10,
    parameter int HIST_W = 10,
    parameter int CTR_W  = 2,
    parameter int TAG_W  = 8,
    parameter bit GSHARE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    gshare_btb_predictor_if.slave bus,
    output logic                  init_done,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;

    localparam logic [CTR_W-1:0]  CTR_ZERO    = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]  CTR_ONE     = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0]  CTR_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]  IDX_ZERO    = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_LAST    = {IDX_W{1'b1}};
    localparam logic [HIST_W-1:0] HIST_ZERO   = {HIST_W{1'b0}};
    localparam logic [TAG_W-1:0]  TAG_ZERO    = {TAG_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Control and statistics registers
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [31:0]       lookups_q, lookups_d;
    logic [31:0]       mispredicts_q, mispredicts_d;

    // Storage arrays (no reset; cleared by the INIT sweep)
    logic [CTR_W-1:0]  pht_q        [ENTRIES];
    logic              btb_valid_q  [ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q    [ENTRIES];
    logic [31:0]       btb_target_q [ENTRIES];

    // Lookup path
    logic [IDX_W-1:0]  lk_line_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic [IDX_W-1:0]  lk_pidx_s;
    logic              lk_hit_s;
    logic              lk_dir_s;

    // Update path and array write ports
    logic [IDX_W-1:0]  up_line_s;
    logic [TAG_W-1:0]  up_tag_s;
    logic [IDX_W-1:0]  up_pidx_s;
    logic              up_en_s;
    logic              up_dir_s;
    logic              pht_we_s;
    logic [IDX_W-1:0]  pht_widx_s;
    logic [CTR_W-1:0]  pht_wdata_s;
    logic              btb_we_s;
    logic [IDX_W-1:0]  btb_widx_s;
    logic              btb_wvalid_s;
    logic [TAG_W-1:0]  btb_wtag_s;
    logic [31:0]       btb_wtarget_s;

    // Only the index and tag fields of the PCs feed the predictor
    logic              unused_pc_bits_s;
    assign unused_pc_bits_s = ^{bus.pred_pc, bus.upd_pc};

    // PHT index: cache-line style PC index, optionally hashed with history
    function automatic logic [IDX_W-1:0] pht_hash(
        input logic [IDX_W-1:0]  line_idx,
        input logic [HIST_W-1:0] hist
    );
        logic [IDX_W-1:0] hist_ext;
        hist_ext = IDX_W'(hist);
        if (GSHARE) begin
            return line_idx ^ hist_ext;
        end else begin
            return line_idx;
        end
    endfunction

    // Next counter value: jumps saturate high, branches step with saturation
    function automatic logic [CTR_W-1:0] ctr_next(
        input logic [CTR_W-1:0] cur,
        input logic             taken,
        input logic             jump
    );
        logic [CTR_W-1:0] nxt;
        nxt = cur;
        if (jump) begin
            nxt = CTR_MAX;
        end else if (taken) begin
            if (cur != CTR_MAX) begin
                nxt = cur + CTR_ONE;
            end else begin
                nxt = cur;
            end
        end else begin
            if (cur != CTR_ZERO) begin
                nxt = cur - CTR_ONE;
            end else begin
                nxt = cur;
            end
        end
        return nxt;
    endfunction

    // Lookup address decode and raw array reads (pre-edge state, no bypass)
    always_comb begin
        lk_line_s = bus.pred_pc[IDX_W+1:2];
        lk_tag_s  = bus.pred_pc[IDX_W+TAG_W+1:IDX_W+2];
        lk_pidx_s = pht_hash(lk_line_s, ghr_q);
        lk_hit_s  = btb_valid_q[lk_line_s] && (btb_tag_q[lk_line_s] == lk_tag_s);
        lk_dir_s  = pht_q[lk_pidx_s][CTR_W-1];
    end

    // Prediction outputs, forced quiet until the sweep has finished
    always_comb begin
        bus.pred_taken   = 1'b0;
        bus.pred_btb_hit = 1'b0;
        bus.pred_target  = 32'h0000_0000;
        bus.pred_hist    = HIST_ZERO;
        if (state_q == ST_RUN) begin
            bus.pred_btb_hit = lk_hit_s;
            bus.pred_taken   = lk_hit_s & lk_dir_s;
            bus.pred_hist    = ghr_q;
            if (lk_hit_s) begin
                bus.pred_target = btb_target_q[lk_line_s];
            end else begin
                bus.pred_target = 32'h0000_0000;
            end
        end else begin
            bus.pred_taken   = 1'b0;
            bus.pred_btb_hit = 1'b0;
            bus.pred_target  = 32'h0000_0000;
            bus.pred_hist    = HIST_ZERO;
        end
    end

    // Status outputs come straight from registers
    always_comb begin
        init_done        = (state_q == ST_RUN);
        stat_lookups     = lookups_q;
        stat_mispredicts = mispredicts_q;
    end

    // Next state: sweep sequencing, training writes, history and statistics
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ghr_d         = ghr_q;
        lookups_d     = lookups_q;
        mispredicts_d = mispredicts_q;
        pht_we_s      = 1'b0;
        pht_widx_s    = IDX_ZERO;
        pht_wdata_s   = CTR_ZERO;
        btb_we_s      = 1'b0;
        btb_widx_s    = IDX_ZERO;
        btb_wvalid_s  = 1'b0;
        btb_wtag_s    = TAG_ZERO;
        btb_wtarget_s = 32'h0000_0000;

        up_line_s = bus.upd_pc[IDX_W+1:2];
        up_tag_s  = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
        up_pidx_s = pht_hash(up_line_s, bus.upd_hist);
        up_en_s   = bus.upd_valid & (bus.upd_branch | bus.upd_jump);
        up_dir_s  = bus.upd_taken | bus.upd_jump;

        if (rst) begin
            state_d       = ST_INIT;
            ptr_d         = IDX_ZERO;
            ghr_d         = HIST_ZERO;
            lookups_d     = 32'h0000_0000;
            mispredicts_d = 32'h0000_0000;
        end else begin
            case (state_q)
                ST_INIT: begin
                    pht_we_s    = 1'b1;
                    pht_widx_s  = ptr_q;
                    pht_wdata_s = CTR_WEAK_NT;
                    btb_we_s    = 1'b1;
                    btb_widx_s  = ptr_q;
                    ptr_d       = ptr_q + IDX_ONE;
                    if (ptr_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_RUN: begin
                    if (up_en_s) begin
                        pht_we_s    = 1'b1;
                        pht_widx_s  = up_pidx_s;
                        pht_wdata_s = ctr_next(pht_q[up_pidx_s], bus.upd_taken, bus.upd_jump);
                        ghr_d       = {ghr_q[HIST_W-2:0], up_dir_s};
                        if (up_dir_s) begin
                            btb_we_s      = 1'b1;
                            btb_widx_s    = up_line_s;
                            btb_wvalid_s  = 1'b1;
                            btb_wtag_s    = up_tag_s;
                            btb_wtarget_s = bus.upd_target;
                        end else begin
                            btb_we_s = 1'b0;
                        end
                    end else begin
                        pht_we_s = 1'b0;
                    end
                    if (bus.pred_req & ~bus.stall) begin
                        lookups_d = lookups_q + 32'h0000_0001;
                    end else begin
                        lookups_d = lookups_q;
                    end
                    if (bus.upd_valid & bus.upd_mispredict) begin
                        mispredicts_d = mispredicts_q + 32'h0000_0001;
                    end else begin
                        mispredicts_d = mispredicts_q;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    ptr_d   = IDX_ZERO;
                end
            endcase
        end
    end

    // Control and statistics registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            ptr_q         <= IDX_ZERO;
            ghr_q         <= HIST_ZERO;
            lookups_q     <= 32'h0000_0000;
            mispredicts_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            ghr_q         <= ghr_d;
            lookups_q     <= lookups_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    // Single write port per array, SRAM style
    always_ff @(posedge clk) begin
        if (pht_we_s) begin
            pht_q[pht_widx_s] <= pht_wdata_s;
        end
        if (btb_we_s) begin
            btb_valid_q[btb_widx_s]  <= btb_wvalid_s;
            btb_tag_q[btb_widx_s]    <= btb_wtag_s;
            btb_target_q[btb_widx_s] <= btb_wtarget_s;
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: a bimodal (dut0) and a gshare (dut1)
// instance share one stimulus stream. Stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares.
module tb_gshare_btb_predictor;

    localparam int IDX_W  = 4;
    localparam int HIST_W = 4;
    localparam int CTR_W  = 2;
    localparam int TAG_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              pred_req;
    logic              stall;
    logic [31:0]       pred_pc;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_branch;
    logic              upd_jump;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;

    logic        init0, init1;
    logic [31:0] lk0, mp0, lk1, mp1;

    gshare_btb_predictor_if #(.HIST_W(HIST_W)) if0 ();
    gshare_btb_predictor_if #(.HIST_W(HIST_W)) if1 ();

    assign if0.pred_req = pred_req;        assign if1.pred_req = pred_req;
    assign if0.stall = stall;              assign if1.stall = stall;
    assign if0.pred_pc = pred_pc;          assign if1.pred_pc = pred_pc;
    assign if0.upd_valid = upd_valid;      assign if1.upd_valid = upd_valid;
    assign if0.upd_pc = upd_pc;            assign if1.upd_pc = upd_pc;
    assign if0.upd_hist = upd_hist;        assign if1.upd_hist = upd_hist;
    assign if0.upd_branch = upd_branch;    assign if1.upd_branch = upd_branch;
    assign if0.upd_jump = upd_jump;        assign if1.upd_jump = upd_jump;
    assign if0.upd_taken = upd_taken;      assign if1.upd_taken = upd_taken;
    assign if0.upd_target = upd_target;    assign if1.upd_target = upd_target;
    assign if0.upd_mispredict = upd_mispredict;
    assign if1.upd_mispredict = upd_mispredict;

    gshare_btb_predictor #(
        .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .TAG_W(TAG_W), .GSHARE(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .init_done(init0),
        .stat_lookups(lk0), .stat_mispredicts(mp0)
    );

    gshare_btb_predictor #(
        .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .TAG_W(TAG_W), .GSHARE(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .init_done(init1),
        .stat_lookups(lk1), .stat_mispredicts(mp1)
    );

    typedef struct {
        int          dut;
        bit          is_stat;
        string       name;
        logic        init;
        logic        taken;
        logic        hit;
        logic [31:0] target;
        logic [31:0] hist;
        logic [31:0] lk;
        logic [31:0] mp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare every expectation queued for the current cycle
    exp_t        mon_e;
    logic        a_init, a_taken, a_hit;
    logic [31:0] a_target, a_hist, a_lk, a_mp;
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.dut == 0) begin
                a_init = init0; a_taken = if0.pred_taken; a_hit = if0.pred_btb_hit;
                a_target = if0.pred_target; a_hist = 32'(if0.pred_hist);
                a_lk = lk0; a_mp = mp0;
            end else begin
                a_init = init1; a_taken = if1.pred_taken; a_hit = if1.pred_btb_hit;
                a_target = if1.pred_target; a_hist = 32'(if1.pred_hist);
                a_lk = lk1; a_mp = mp1;
            end
            if (mon_e.is_stat) begin
                check({mon_e.name, ".stat_lookups"}, a_lk, mon_e.lk);
                check({mon_e.name, ".stat_mispredicts"}, a_mp, mon_e.mp);
            end else begin
                check({mon_e.name, ".init_done"}, {31'd0, a_init}, {31'd0, mon_e.init});
                check({mon_e.name, ".pred_taken"}, {31'd0, a_taken}, {31'd0, mon_e.taken});
                check({mon_e.name, ".pred_btb_hit"}, {31'd0, a_hit}, {31'd0, mon_e.hit});
                check({mon_e.name, ".pred_target"}, a_target, mon_e.target);
                check({mon_e.name, ".pred_hist"}, a_hist, mon_e.hist);
            end
        end
    end

    task automatic exp_pred(input int dut, input string name, input logic init, input logic taken,
                            input logic hit, input logic [31:0] target, input logic [31:0] hist);
        exp_t e;
        e.dut = dut; e.is_stat = 1'b0; e.name = name; e.init = init; e.taken = taken;
        e.hit = hit; e.target = target; e.hist = hist; e.lk = 32'd0; e.mp = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic exp_stat(input int dut, input string name, input logic [31:0] lk, input logic [31:0] mp);
        exp_t e;
        e.dut = dut; e.is_stat = 1'b1; e.name = name; e.init = 1'b0; e.taken = 1'b0;
        e.hit = 1'b0; e.target = 32'd0; e.hist = 32'd0; e.lk = lk; e.mp = mp;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        pred_req = 1'b0; stall = 1'b0; upd_valid = 1'b0; upd_branch = 1'b0;
        upd_jump = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0; upd_hist = 4'h0;
    endtask

    // One clock: inputs set before the call are seen at this edge, then cleared
    task automatic cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic upd(input logic [31:0] pc, input logic [3:0] hist, input logic br, input logic jp,
                       input logic tk, input logic [31:0] tgt, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_hist = hist; upd_branch = br; upd_jump = jp;
        upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
    endtask

    task automatic lookup(input logic [31:0] pc);
        pred_req = 1'b1; pred_pc = pc;
    endtask

    task automatic reset_sweep();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (16) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; pred_pc = 32'h0; upd_pc = 32'h0; upd_target = 32'h0;
        idle_inputs();
        cycle();

        // Reset sweep: 16 INIT cycles with quiet outputs, updates ignored
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lookup(32'h100);
            upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
            exp_pred(0, "sweep_d0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            exp_pred(1, "sweep_d1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            exp_stat(0, "sweep_stat", 32'd0, 32'd0);
            cycle();
        end
        lookup(32'h100);
        exp_pred(0, "sweep_done_d0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_pred(1, "sweep_done_d1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_stat(0, "sweep_done_stat", 32'd0, 32'd0);
        cycle();

        // Bimodal training and counter saturation at both ends
        reset_sweep();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        lookup(32'h100); exp_pred(0, "train_tt", 1'b1, 1'b1, 1'b1, 32'h200, 32'h3); cycle();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        lookup(32'h100); exp_pred(0, "train_sat_hi", 1'b1, 1'b1, 1'b1, 32'h200, 32'h7); cycle();
        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0); cycle();
        end
        lookup(32'h100); exp_pred(0, "train_nnn", 1'b1, 1'b0, 1'b1, 32'h200, 32'h8); cycle();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0); cycle();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        lookup(32'h100); exp_pred(0, "train_sat_lo", 1'b1, 1'b0, 1'b1, 32'h200, 32'h1); cycle();

        // Jump: counter forced to all-ones, history shifts in a 1
        reset_sweep();
        upd(32'h40, 4'h0, 1'b0, 1'b1, 1'b0, 32'h80, 1'b0); cycle();
        lookup(32'h40);
        exp_pred(0, "jump_d0", 1'b1, 1'b1, 1'b1, 32'h80, 32'h1);
        exp_pred(1, "jump_d1", 1'b1, 1'b0, 1'b1, 32'h80, 32'h1);
        cycle();

        // Gshare: same PC, different history, different counters
        reset_sweep();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        upd(32'h100, 4'h3, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0); cycle();
        upd(32'h100, 4'h3, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0); cycle();
        for (int i = 0; i < 4; i++) begin
            upd(32'h104, 4'h0, 1'b1, 1'b0, 1'b0, 32'h204, 1'b0); cycle();
        end
        lookup(32'h100); exp_pred(1, "gshare_h0", 1'b1, 1'b1, 1'b1, 32'h200, 32'h0); cycle();
        for (int i = 0; i < 2; i++) begin
            upd(32'h108, 4'h0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0); cycle();
        end
        lookup(32'h100); exp_pred(1, "gshare_h3", 1'b1, 1'b0, 1'b1, 32'h200, 32'h3); cycle();
        lookup(32'h140);
        exp_pred(1, "tag_miss_d1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h3);
        exp_pred(0, "tag_miss_d0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h3);
        cycle();

        // Same-cycle lookup and update: lookup sees pre-edge state
        reset_sweep();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); cycle();
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0); cycle();
        lookup(32'h100);
        upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
        exp_pred(0, "hazard_old", 1'b1, 1'b0, 1'b1, 32'h200, 32'h2);
        cycle();
        lookup(32'h100); exp_pred(0, "hazard_new", 1'b1, 1'b1, 1'b1, 32'h200, 32'h5); cycle();

        // Statistics
        reset_sweep();
        lookup(32'h100); upd(32'h100, 4'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1); cycle();
        lookup(32'h100); stall = 1'b1; cycle();
        lookup(32'h100); upd_mispredict = 1'b1; cycle();
        lookup(32'h100); upd_valid = 1'b1; upd_mispredict = 1'b1; cycle();
        lookup(32'h100); cycle();
        pred_pc = 32'h100;
        exp_stat(0, "stats_d0", 32'd4, 32'd2);
        exp_stat(1, "stats_d1", 32'd4, 32'd2);
        exp_pred(0, "stats_pred", 1'b1, 1'b1, 1'b1, 32'h200, 32'h1);
        cycle();

        // Reset in RUN clears counters and history, then reset mid-sweep restarts it
        rst = 1'b1; cycle(); rst = 1'b0;
        exp_pred(0, "midrun_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_stat(0, "midrun_rst_stat", 32'd0, 32'd0);
        cycle();
        repeat (4) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_pred(0, "resweep", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            cycle();
        end
        pred_pc = 32'h100;
        exp_pred(0, "resweep_done", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_stat(0, "resweep_stat", 32'd0, 32'd0);
        cycle();

        cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
